// File: rtl/dfp_line_mem_responder.sv
// Memory-side responder for the cache DFP interface: line-granular store with
// fixed programmable read/write latency, preload port, sticky error flag and counters.
module dfp_line_mem_responder #(
    parameter int unsigned LINES         = 64,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              dfp_addr,
    input  logic                     dfp_read,
    input  logic                     dfp_write,
    input  logic [255:0]             dfp_wdata,
    output logic [255:0]             dfp_rdata,
    output logic                     dfp_resp,
    input  logic                     init_we,
    input  logic [$clog2(LINES)-1:0] init_idx,
    input  logic [255:0]             init_line,
    output logic                     err,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_op_wr;
    logic [IDX_W-1:0]   r_idx;
    logic [LINE_W-1:0]  r_wdata;
    logic [LINE_W-1:0]  r_rdata;
    logic               r_resp;
    logic               r_err;
    logic [15:0]        r_rd_count;
    logic [15:0]        r_wr_count;
    logic [LINE_W-1:0]  r_mem [LINES];

    logic               w_req;
    logic               w_op_wr;
    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_err_set;
    logic               w_commit;
    logic               w_nxt_rd;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_addr_unused;

    assign w_req    = dfp_read | dfp_write;
    // A simultaneous read+write is serviced as a write.
    assign w_op_wr  = dfp_write;
    assign w_idx    = dfp_addr[5 +: IDX_W];
    // Upper address bits alias onto the store.
    assign w_addr_unused = ^dfp_addr[31:5+IDX_W];

    assign w_commit = (r_state == RESP) & r_op_wr;
    assign w_nxt_rd = (r_state == IDLE) ? ~w_op_wr : ~r_op_wr;
    assign w_rd_idx = (r_state == IDLE) ? w_idx : r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept  = 1'b1;
                    w_err_set = (dfp_read & dfp_write) | (dfp_addr[4:0] != 5'd0);
                    if (w_op_wr) begin
                        w_cnt_nxt   = CNT_W'(WRITE_LATENCY - 1);
                        w_state_nxt = (WRITE_LATENCY == 1) ? RESP : BUSY;
                    end else begin
                        w_cnt_nxt   = CNT_W'(READ_LATENCY - 1);
                        w_state_nxt = (READ_LATENCY == 1) ? RESP : BUSY;
                    end
                end
            end
            BUSY: begin
                // Initiator withdrew the request: abort silently and flag it.
                if (!w_req) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, latency counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_op_wr <= w_op_wr;
                r_idx   <= w_idx;
                r_wdata <= dfp_wdata;
            end
            r_resp  <= (w_state_nxt == RESP);
            r_rdata <= ((w_state_nxt == RESP) && w_nxt_rd) ? r_mem[w_rd_idx] : '0;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Completion counters, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == RESP) begin
            if (r_op_wr) begin
                if (r_wr_count != CNT_SAT) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end else begin
                if (r_rd_count != CNT_SAT) begin
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end
        end
    end

    // Backing store is never cleared; the DFP write is ordered last so it wins a same-index preload.
    always_ff @(posedge clk) begin
        if (init_we) begin
            r_mem[init_idx] <= init_line;
        end
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign dfp_rdata = r_rdata;
    assign dfp_resp  = r_resp;
    assign err       = r_err;
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;

endmodule

// File: doc/dfp_line_mem_responder.md
Name: dfp_line_mem_responder

Overview:
- Memory-side responder for the cache DFP interface.
- Accepts 256-bit line read and write requests from a cache and holds the requests in a line-granular backing store.
- Returns a one-cycle dfp_resp after a programmable fixed latency.
- Used as the physical-memory model beneath the cache in block-level and integration benches; also synthesizable as an FPGA BRAM-backed memory.

Parameters:
- LINES, 64: number of 256-bit lines in the store; power of two, ≥2.
- READ_LATENCY, 4: cycles from request acceptance to dfp_resp for reads; ≥1.
- WRITE_LATENCY, 3: cycles from request acceptance to dfp_resp for writes; ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- dfp_addr  input  32  line address; bits [4:0] expected 0.
- dfp_read  input  1  line read request; held until dfp_resp.
- dfp_write  input  1  line write request; held until dfp_resp.
- dfp_wdata  input  256  write line data; held with dfp_write.
- dfp_rdata  output  256  read line data; valid only while dfp_resp=1 on a read.
- dfp_resp  output  1  one-cycle completion pulse.
- init_we  input  1  bench/boot preload strobe.
- init_idx  input  $clog2(LINES)  preload line index.
- init_line  input  256  preload line data.
- err  output  1  sticky protocol-error flag.
- rd_count  output  16  completed reads; saturates at 16'hFFFF.
- wr_count  output  16  completed writes; saturates at 16'hFFFF.

Behaviour:
- Reset values (rst_n=0, asynchronous): state=IDLE, dfp_resp=0, dfp_rdata=0, err=0, rd_count=0, wr_count=0. Store contents are not cleared.
- Line index = dfp_addr[5 +: $clog2(LINES)]. Upper address bits are ignored, so higher addresses alias onto the store.
- States:
  - IDLE:
    - If dfp_read|dfp_write, capture op, index and dfp_wdata, and load cnt = LAT-1.
    - If LAT=1, go to RESP; otherwise go to BUSY.
    - LAT is READ_LATENCY or WRITE_LATENCY according to the captured op.
  - BUSY:
    - cnt decrements each cycle; at cnt==1 the next state is RESP.
    - If the initiator drops both dfp_read and dfp_write while in BUSY: abort to IDLE, set err, no response, no store write.
  - RESP:
    - dfp_resp=1 for exactly one cycle.
    - Read: dfp_rdata = store[idx], registered so it is valid in the same cycle as dfp_resp.
    - Write: store[idx] <= captured wdata on the clock edge that ends RESP.
    - Increment the matching counter (saturating).
    - Unconditionally return to IDLE.
- Latency: a request first visible in cycle T produces dfp_resp in cycle T+LAT.
- Request ordering: the initiator deasserts in the cycle after dfp_resp. IDLE may accept a new request in that cycle. The write_back→allocate sequence (write then immediately a read) must therefore work back-to-back with no idle gap required.
- A read of a line written by the immediately preceding write returns the new data.
- Error conditions (all sticky until reset):
  - Both dfp_read and dfp_write asserted at acceptance: set err and service the request as a write.
  - dfp_addr[4:0]≠0 at acceptance: set err and service normally with bits [4:0] ignored.
- Outside RESP, dfp_rdata=0 and dfp_resp=0.
- Preload:
  - init_we writes init_line to store[init_idx] in any state.
  - If it coincides with a RESP-cycle DFP write to the same index, the DFP write wins.
  - Preload never affects an in-flight read's captured data; read data is taken in RESP.
- Reset asserted mid-transaction: the transaction is dropped, no dfp_resp is issued and a pending write is not committed. The store keeps its prior contents.

Test Plan:
- Preload idx 3 with 256'hA5…A5, then dfp_read addr 32'h0000_0060 → dfp_resp exactly 4 cycles after request, dfp_rdata=A5…A5, rd_count=1, err=0.
- dfp_write addr 32'h0000_0020 with wdata 256'h1234…; on resp drop write and raise read to the same address next cycle → write resp at +3, read resp at +4 after acceptance, rdata=1234…, wr_count=1, rd_count=1.
- Aliasing: write addr 32'h0000_0800 (LINES=64, idx 0), read addr 32'h0000_0000 → same data returned.
- Misaligned read addr 32'h0000_0064 → serviced as idx 3, err=1 and err stays 1 until rst_n pulse.
- Write request dropped after 1 cycle of BUSY → no dfp_resp, err=1, store[idx] unchanged, wr_count=0.
- rst_n asserted low 2 cycles into a write → dfp_resp never asserts, store unchanged, counters and err return to 0, next read completes normally.
